// File: rtl/dot_accum_pkg.sv
// dot_accum_pkg: shared states, mode encodings and default sizes for dot_accum
package dot_accum_pkg;
  localparam int DATA_W_D = 27;
  localparam int DEPTH_D = 1000;
  localparam int ADDR_W_D = 10;
  localparam int ACC_W_D = 64;
  localparam logic MODE_NORM2 = 1'b0;
  localparam logic MODE_DOT = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/dot_accum_dp_array.sv
// dp_array: DATA_W x DEPTH synchronous RAM, host read/write port plus engine read port
module dp_array #(
  parameter int DATA_W = 27,
  parameter int DEPTH = 1000,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              e_en,
  input  logic [ADDR_W-1:0] e_addr,
  output logic [DATA_W-1:0] e_rdata
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  // host writes; contents survive reset, out-of-range addresses dropped
  always_ff @(posedge clk)
    if (h_we && {1'b0, h_addr} < DEPTH_L) mem[h_addr] <= h_wdata;
  // host read, one-cycle latency, cleared by reset
  always_ff @(posedge clk)
    h_rdata <= rst ? '0 : mem[h_addr];
  // engine read, only clocked while the engine is streaming
  always_ff @(posedge clk)
    if (e_en) e_rdata <= mem[e_addr];
endmodule

// File: rtl/dot_accum.sv
// dot_accum: two-array signed norm2 / dot-product engine with host load port
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              controlArr,
  input  logic              ctrlSel,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  input  logic              mode,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ADDR_W-1:0] end_i,
  input  logic [ACC_W-1:0]  init_acc,
  output logic              busy,
  output logic              w_enable,
  output logic [ACC_W-1:0]  result
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_t state;
  logic mode_q, sel_q, v1, v2, idle, start, host_we, e_en;
  logic [ADDR_W:0] idx, end_q, end_clamp;
  logic [DATA_W-1:0] a_h, b_h, a_e, b_e;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  assign idle = state == S_IDLE;
  assign start = idle && r_enable && !controlArr;
  assign host_we = idle && controlArr && controlArrWEnable_a;
  assign e_en = state == S_RUN;
  assign end_clamp = {1'b0, end_i} > DEPTH_L ? DEPTH_L : {1'b0, end_i};
  assign busy = !idle;
  assign w_enable = state == S_DONE;
  assign controlArrRData_a = sel_q ? b_h : a_h;
  dp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_a (
    .clk(clk), .rst(rst), .h_we(host_we && !ctrlSel), .h_addr(controlArrAddr_a),
    .h_wdata(controlArrWData_a), .h_rdata(a_h), .e_en(e_en),
    .e_addr(idx[ADDR_W-1:0]), .e_rdata(a_e)
  );
  dp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_b (
    .clk(clk), .rst(rst), .h_we(host_we && ctrlSel), .h_addr(controlArrAddr_a),
    .h_wdata(controlArrWData_a), .h_rdata(b_h), .e_en(e_en && mode_q == MODE_DOT),
    .e_addr(idx[ADDR_W-1:0]), .e_rdata(b_e)
  );
  // full-width signed product; norm2 squares A
  always_ff @(posedge clk)
    prod <= $signed(a_e) * $signed(mode_q == MODE_DOT ? b_e : a_e);
  // control FSM, index counter, valid pipeline and wrapping accumulator
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      acc <= '0;
      result <= '0;
      sel_q <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      mode_q <= MODE_NORM2;
      idx <= '0;
      end_q <= '0;
    end else begin
      sel_q <= ctrlSel;
      v1 <= e_en;
      v2 <= v1;
      if (v2) acc <= acc + ACC_W'(prod);
      if (start) begin
        mode_q <= mode;
        idx <= {1'b0, init_i};
        end_q <= end_clamp;
        acc <= init_acc;
        state <= {1'b0, init_i} < end_clamp ? S_RUN : S_DRAIN;
      end else if (state == S_RUN) begin
        idx <= idx + 1'b1;
        if (idx + 1'b1 == end_q) state <= S_DRAIN;
      end else if (state == S_DRAIN && !v1 && !v2) begin
        state <= S_DONE;
        result <= acc;
      end else if (state == S_DONE) state <= S_IDLE;
    end
endmodule
